// File: rtl/accum_adder_pkg.sv
// Shared definitions for the registered add/sub/accumulate block.
// The mode encoding matches the 2-bit mode port of accum_adder.
package accum_adder_pkg;

   typedef enum logic [1:0] {
      MODE_ADD  = 2'b00,
      MODE_SUB  = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

endpackage

// File: rtl/accum_adder_sat_addsub.sv
// Combinational WIDTH-bit add/subtract with a carry/borrow flag.
// When SATURATE is set, the sum is optionally clamped.
module sat_addsub #(
   parameter int unsigned WIDTH    = 8,
   parameter bit          SATURATE = 1'b1
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] raw;

   // NOTE: every output of a combinational block gets a value before any branch,
   // otherwise paths that skip an assignment infer a latch.
   always_comb begin
      raw   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
      carry = raw[WIDTH];
      sum   = raw[WIDTH-1:0];
      // A borrow sets the MSB as well, so one flag covers both directions.
      if (SATURATE && carry) begin
         sum = sub ? '0 : '1;
      end
   end

endmodule

// File: rtl/accum_adder.sv
// Registered add/sub/accumulate stage with a valid/ready output register,
// an accumulator, and a sticky overflow flag.
module accum_adder
   import accum_adder_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter bit          SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf_sticky,
   output logic [WIDTH-1:0] acc
);

   mode_e            op;
   logic             accept;
   logic [WIDTH-1:0] x_op;
   logic [WIDTH-1:0] y_op;
   logic [WIDTH-1:0] alu_sum;
   logic             alu_carry;
   logic [WIDTH-1:0] next_result;
   logic             next_carry;

   assign op       = mode_e'(mode);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // ACC reuses the adder as acc + a, so the operand a moves to the y side.
   assign x_op = (op == MODE_ACC) ? acc : a;
   assign y_op = (op == MODE_ACC) ? a   : b;

   sat_addsub #(
      .WIDTH   (WIDTH),
      .SATURATE(SATURATE)
   ) u_alu (
      .x    (x_op),
      .y    (y_op),
      .sub  (op == MODE_SUB),
      .sum  (alu_sum),
      .carry(alu_carry)
   );

   always_comb begin
      next_result = alu_sum;
      next_carry  = alu_carry;
      if (op == MODE_LOAD) begin
         next_result = a;
         next_carry  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= next_result;
         carry     <= next_carry;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // LOAD outranks a clear; a clear outranks an ACC write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (accept && op == MODE_LOAD) begin
         acc <= a;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (accept && op == MODE_ACC) begin
         acc <= alu_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (acc_clr) begin
         ovf_sticky <= 1'b0;
      end else if (accept && next_carry) begin
         ovf_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_accum_adder.sv
// Directed and random checks of accum_adder, with a saturating and a wrapping
// instance driven by the same stimulus.
module tb_accum_adder;
   import accum_adder_pkg::*;

   typedef struct packed {
      logic       v;
      logic [7:0] r;
      logic       c;
      logic       s;
      logic [7:0] acc;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic       acc_clr;
   logic [1:0] mode;
   logic [7:0] a;
   logic [7:0] b;

   logic       ir  [2];
   logic       ov  [2];
   logic [7:0] res [2];
   logic       cy  [2];
   logic       st  [2];
   logic [7:0] ac  [2];

   int total = 0;
   int bad   = 0;

   accum_adder #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .mode(mode), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(ov[0]),
      .out_ready(out_ready), .result(res[0]), .carry(cy[0]),
      .ovf_sticky(st[0]), .acc(ac[0])
   );

   accum_adder #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .mode(mode), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(ov[1]),
      .out_ready(out_ready), .result(res[1]), .carry(cy[1]),
      .ovf_sticky(st[1]), .acc(ac[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t obs(input int i);
      return '{ov[i], res[i], cy[i], st[i], ac[i]};
   endfunction

   function automatic obs_t mk(input logic v, input logic [7:0] r, input logic c,
                               input logic s, input logic [7:0] accv);
      return '{v, r, c, s, accv};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("v=%b r=%0d c=%b s=%b acc=%0d", o.v, o.r, o.c, o.s, o.acc);
   endfunction

   // Reference arithmetic in plain integers: returns {carry, result}.
   function automatic logic [8:0] ref_op(input logic [1:0] m, input logic [7:0] av,
                                         input logic [7:0] bv, input logic [7:0] accv,
                                         input bit sat);
      int s;
      case (m)
         MODE_ADD: s = int'(av) + int'(bv);
         MODE_SUB: s = int'(av) - int'(bv);
         MODE_ACC: s = int'(accv) + int'(av);
         default:  return {1'b0, av};
      endcase
      if (s > 255) return {1'b1, sat ? 8'hFF : 8'(s - 256)};
      if (s < 0)   return {1'b1, sat ? 8'h00 : 8'(s + 256)};
      return {1'b0, 8'(s)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input mode_e m, input logic [7:0] av, input logic [7:0] bv,
                       input logic clr);
      mode     = m;
      a        = av;
      b        = bv;
      acc_clr  = clr;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_clr  = 1'b0;
   endtask

   task automatic test_reset();
      obs_t exp [2];
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== mk(0, 0, 0, 0, 0) || ir[i] !== 1'b1) begin
            bad++;
            $display("FAIL reset_init[%0d] got %s ir=%b want all zero ir=1", i, fmt(obs(i)), ir[i]);
         end
      end
      tick();
      @(posedge clk);
      #1 rst_n = 1'b1;

      out_ready = 1'b0;
      beat(MODE_LOAD, 8'd7, 8'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 7, 0, 0, 7);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL reset_pre[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== mk(0, 0, 0, 0, 0) || ir[i] !== 1'b1) begin
            bad++;
            $display("FAIL reset_async[%0d] got %s ir=%b want all zero ir=1", i, fmt(obs(i)), ir[i]);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_release[%0d] got ir=%b ov=%b want ir=1 ov=0", i, ir[i], ov[i]);
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_add();
      obs_t exp [2];
      beat(MODE_ADD, 8'd200, 8'd100, 1'b0);
      exp[0] = mk(1, 255, 1, 1, 0);
      exp[1] = mk(1, 44, 1, 1, 0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL add_ovf[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      tick();
      exp[0] = mk(0, 255, 1, 1, 0);
      exp[1] = mk(0, 44, 1, 1, 0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL add_drain[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
   endtask

   task automatic test_sub();
      obs_t exp [2];
      beat(MODE_SUB, 8'd5, 8'd9, 1'b0);
      exp[0] = mk(1, 0, 1, 1, 0);
      exp[1] = mk(1, 252, 1, 1, 0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL sub_under[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_SUB, 8'd9, 8'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 4, 0, 1, 0);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL sub_plain[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
   endtask

   task automatic test_acc();
      obs_t exp [2];
      out_ready = 1'b0;
      acc_clr   = 1'b1;
      tick();
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 4, 0, 0, 0);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL clr_only[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_LOAD, 8'd10, 8'd99, 1'b0);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 10, 0, 0, 10);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL acc_load[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_ACC, 8'd20, 8'd99, 1'b0);
      beat(MODE_ACC, 8'd30, 8'd99, 1'b0);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 60, 0, 0, 60);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL acc_chain[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_ACC, 8'd1, 8'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 61, 0, 0, 0);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL acc_with_clr[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_LOAD, 8'd7, 8'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 7, 0, 0, 7);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL load_with_clr[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      // 7 + 255 overflows, but the clear on the same edge drops the sticky set.
      beat(MODE_ACC, 8'd255, 8'd0, 1'b1);
      exp[0] = mk(1, 255, 1, 0, 0);
      exp[1] = mk(1, 6, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL acc_ovf_clr[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      beat(MODE_ACC, 8'd255, 8'd0, 1'b0);
      beat(MODE_ACC, 8'd2, 8'd0, 1'b0);
      exp[0] = mk(1, 255, 1, 1, 255);
      exp[1] = mk(1, 1, 1, 1, 1);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL acc_ovf[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      obs_t exp [2];
      logic [7:0] acc_exp [2];
      acc_exp[0] = 8'd255;
      acc_exp[1] = 8'd1;
      out_ready = 1'b0;
      mode      = MODE_ADD;
      a         = 8'd1;
      b         = 8'd2;
      in_valid  = 1'b1;
      tick();
      a = 8'd50;
      b = 8'd60;
      for (int k = 0; k < 3; k++) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            total++;
            if (ir[i] !== 1'b0 || ov[i] !== 1'b1 || res[i] !== 8'd3) begin
               bad++;
               $display("FAIL stall%0d[%0d] got ir=%b ov=%b r=%0d want ir=0 ov=1 r=3",
                        k, i, ir[i], ov[i], res[i]);
            end
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (ir[i] !== 1'b1 || ov[i] !== 1'b1) begin
            bad++;
            $display("FAIL release[%0d] got ir=%b ov=%b want ir=1 ov=1", i, ir[i], ov[i]);
         end
      end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(1, 110, 0, 1, acc_exp[i]);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL drain_accept[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         exp[i] = mk(0, 110, 0, 1, acc_exp[i]);
         total++;
         if (obs(i) !== exp[i]) begin
            bad++;
            $display("FAIL final_drain[%0d] got %s want %s", i, fmt(obs(i)), fmt(exp[i]));
         end
      end
   endtask

   task automatic test_random();
      logic       m_v   [2];
      logic [7:0] m_r   [2];
      logic       m_c   [2];
      logic       m_s   [2];
      logic [7:0] m_acc [2];
      logic [8:0] cr;
      logic       take;
      obs_t       exp;
      int         beats;
      int         cycles;
      beats  = 0;
      cycles = 0;
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      rst_n    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 0; m_r[i] = 0; m_c[i] = 0; m_s[i] = 0; m_acc[i] = 0;
      end
      tick();
      rst_n = 1'b1;
      while (beats < 10000 && cycles < 40000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         acc_clr   = ($urandom_range(15) == 0);
         mode      = 2'($urandom_range(3));
         a         = 8'($urandom);
         b         = 8'($urandom);
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            exp = mk(m_v[i], m_r[i], m_c[i], m_s[i], m_acc[i]);
            total++;
            if (obs(i) !== exp || ir[i] !== (!m_v[i] || out_ready)) begin
               bad++;
               $display("FAIL rand c%0d[%0d] got %s ir=%b want %s ir=%b", cycles, i,
                        fmt(obs(i)), ir[i], fmt(exp), !m_v[i] || out_ready);
            end
            take = in_valid && (!m_v[i] || out_ready);
            cr   = ref_op(mode, a, b, m_acc[i], i == 0);
            if (i == 0 && take) beats++;
            if (take) begin
               m_v[i] = 1'b1;
               m_r[i] = cr[7:0];
               m_c[i] = cr[8];
            end else if (out_ready) begin
               m_v[i] = 1'b0;
            end
            if (take && mode == MODE_LOAD)     m_acc[i] = a;
            else if (acc_clr)                  m_acc[i] = 8'd0;
            else if (take && mode == MODE_ACC) m_acc[i] = cr[7:0];
            if (acc_clr)           m_s[i] = 1'b0;
            else if (take && cr[8]) m_s[i] = 1'b1;
         end
         cycles++;
         tick();
      end
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      total++;
      if (beats < 10000) begin
         bad++;
         $display("FAIL rand_budget got beats=%0d want 10000 within 40000 cycles", beats);
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      acc_clr   = 1'b0;
      mode      = MODE_ADD;
      a         = 8'd0;
      b         = 8'd0;
      test_reset();
      test_add();
      test_sub();
      test_acc();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
